bcd_addsub_serial: RTL



---
 rtl/bcd_addsub_serial_pkg.sv | 16 +
 rtl/bcd_addsub_serial_if.sv | 40 ++++
 rtl/bcd_addsub_serial_digit_add.sv | 36 +++
 rtl/bcd_addsub_serial.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_addsub_serial_pkg.sv
// Shared types and constants for the serial sign-magnitude BCD add/subtract block.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_addsub_serial_if.sv
// Start/busy/done bus of the serial BCD add/subtract block.
// BCD_DIGIT_CHECK_EN adds the err flag for illegal input digits.
interface bcd_addsub_serial_if #(parameter int NDIG = 4);

    logic                start;
    logic                op_sub;
    logic                a_sign;
    logic [4*NDIG-1:0]   a;
    logic                b_sign;
    logic [4*NDIG-1:0]   b;
    logic                busy;
    logic                done;
    logic [4*NDIG-1:0]   result;
    logic                r_sign;
    logic                overflow;
`ifdef BCD_DIGIT_CHECK_EN
    logic                err;

    modport master (
        output start, op_sub, a_sign, a, b_sign, b,
        input  busy, done, result, r_sign, overflow, err
    );

    modport slave (
        input  start, op_sub, a_sign, a, b_sign, b,
        output busy, done, result, r_sign, overflow, err
    );
`else
    modport master (
        output start, op_sub, a_sign, a, b_sign, b,
        input  busy, done, result, r_sign, overflow
    );

    modport slave (
        input  start, op_sub, a_sign, a, b_sign, b,
        output busy, done, result, r_sign, overflow
    );
`endif

endinterface

// File: rtl/bcd_addsub_serial_digit_add.sv
// Single BCD digit adder with optional nine's complement of the y operand.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       cin,
    input  logic       comp_y,
    output bcd_digit_t s,
    output logic       cout
);

    // Binary sums above 9 skip the six unused codes to wrap back into BCD.
    function automatic logic [4:0] bcd_correct(input logic [4:0] bin);
        logic [4:0] r;
        if (bin > 5'd9) begin
            r = {1'b1, bin[3:0] + BCD_CORR};
        end else begin
            r = bin;
        end
        return r;
    endfunction

    bcd_digit_t yv;
    logic [4:0] bin;
    logic [4:0] fixed;

    always_comb begin
        yv    = comp_y ? (BCD_NINE - y) : y;
        bin   = {1'b0, x} + {1'b0, yv} + {4'b0000, cin};
        fixed = bcd_correct(bin);
        s     = fixed[3:0];
        cout  = fixed[4];
    end

endmodule

// File: rtl/bcd_addsub_serial.sv
// NDIG-digit signed BCD add/subtract, one digit per clock LSD first, with a
// recomplement pass for negative differences. BCD_DIGIT_CHECK_EN adds input digit checking.
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_addsub_serial_if.slave bus
);

    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t                   state, state_nxt;
    logic [IDXW-1:0]          idx;
    logic                     carry;
    logic [NDIG-1:0][3:0]     a_q, b_q, result_q, res_nxt;
    logic                     a_sign_q, eb_q, sub_q;
    logic                     r_sign_q, ovf_q;
    logic                     busy_c, done_c;
    logic                     last;
    logic                     eb_in, sub_in;

    bcd_digit_t               add_x, add_y, add_s;
    logic                     add_comp, add_cout;

`ifdef BCD_DIGIT_CHECK_EN
    logic                     err_q;
    logic                     bad_in;

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.a[i*4 +: 4] > BCD_NINE || bus.b[i*4 +: 4] > BCD_NINE) begin
                bad_in = 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`endif

    assign last   = (idx == IDXW'(NDIG - 1));
    assign eb_in  = bus.b_sign ^ bus.op_sub;
    assign sub_in = bus.a_sign ^ eb_in;

    // FIX reuses the digit adder as (9 - result digit) + carry.
    always_comb begin
        add_x    = a_q[idx];
        add_y    = b_q[idx];
        add_comp = sub_q;
        if (state == FIX) begin
            add_x    = '0;
            add_y    = result_q[idx];
            add_comp = 1'b1;
        end
        res_nxt      = result_q;
        res_nxt[idx] = add_s;
    end

    bcd_digit_add u_digit_add (
        .x      (add_x),
        .y      (add_y),
        .cin    (carry),
        .comp_y (add_comp),
        .s      (add_s),
        .cout   (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef BCD_DIGIT_CHECK_EN
                    state_nxt = bad_in ? DONE : ADD;
`else
                    state_nxt = ADD;
`endif
                end
            end
            ADD: begin
                if (last) begin
                    state_nxt = (!sub_q || add_cout) ? DONE : FIX;
                end
            end
            FIX: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state != IDLE);
        done_c = (state == DONE);
    end

    // Sign is settled together with the last digit so it is valid during done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            a_sign_q <= 1'b0;
            eb_q     <= 1'b0;
            sub_q    <= 1'b0;
            result_q <= '0;
            r_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        a_sign_q <= bus.a_sign;
                        eb_q     <= eb_in;
                        sub_q    <= sub_in;
                        carry    <= sub_in;
                        idx      <= '0;
                        ovf_q    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
                        err_q    <= bad_in;
                        if (bad_in) begin
                            result_q <= '0;
                            r_sign_q <= 1'b0;
                        end
`endif
                    end
                end
                ADD: begin
                    result_q <= res_nxt;
                    carry    <= add_cout;
                    idx      <= idx + 1'b1;
                    if (last) begin
                        idx <= '0;
                        if (!sub_q) begin
                            ovf_q    <= add_cout;
                            r_sign_q <= a_sign_q & (|res_nxt);
                        end else if (add_cout) begin
                            r_sign_q <= a_sign_q & (|res_nxt);
                        end else begin
                            carry <= 1'b1;
                        end
                    end
                end
                FIX: begin
                    result_q <= res_nxt;
                    carry    <= add_cout;
                    idx      <= idx + 1'b1;
                    if (last) begin
                        idx      <= '0;
                        r_sign_q <= eb_q & (|res_nxt);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.result   = result_q;
    assign bus.r_sign   = r_sign_q;
    assign bus.overflow = ovf_q;

endmodule
